// File: rtl/com_sender_if.sv
// Bus between the serial command sender and its controller, ROM and SPI slave.
// The master modport is the sender side; slave is everything around it.
interface com_sender_if #(
    parameter int unsigned CMD_W  = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              Write;
    logic [ADDR_W-1:0] rom_addr;
    logic [CMD_W-1:0]  rom_data;
    logic              sclk;
    logic              sdo;
    logic              cs_n;
    logic              NewCom;
    logic              ComEnd;
    logic              busy;

    modport master (
        input  Write,
        input  rom_data,
        output rom_addr,
        output sclk,
        output sdo,
        output cs_n,
        output NewCom,
        output ComEnd,
        output busy
    );

    modport slave (
        output Write,
        output rom_data,
        input  rom_addr,
        input  sclk,
        input  sdo,
        input  cs_n,
        input  NewCom,
        input  ComEnd,
        input  busy
    );
endinterface

// File: rtl/com_sender.sv
// Walks a synchronous command ROM one entry per Write request and sends each
// word MSB first as a mode-0 SPI frame; flags more-to-come or end-of-list.
module com_sender #(
    parameter int unsigned CMD_W   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NUM_CMD = 10,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    com_sender_if.master bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(CMD_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_CMD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] idx_q,     idx_d;
    logic [CMD_W-1:0]  shreg_q,   shreg_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic              sclk_q,    sclk_d;
    logic              sdo_q,     sdo_d;
    logic              cs_n_q,    cs_n_d;
    logic              new_com_q, new_com_d;
    logic              com_end_q, com_end_d;
    logic              busy_q,    busy_d;

    // Next-state and output logic; every register holds unless a state moves it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        new_com_d = 1'b0;
        com_end_d = com_end_q;

        case (state_q)
            IDLE: begin
                if (bus.Write && !com_end_q) begin
                    state_d = FETCH;
                end
            end

            // rom_addr tracks idx continuously, so one wait cycle covers ROM latency.
            FETCH: begin
                state_d = LOAD;
            end

            LOAD: begin
                shreg_d = bus.rom_data;
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end

            // Each half-period is CLK_DIV cycles; data advances on the falling edge.
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = shreg_q << 1;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            cs_n_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                if (idx_q == IDX_LAST) begin
                    com_end_d = 1'b1;
                end else begin
                    new_com_d = 1'b1;
                    idx_d     = idx_q + ADDR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        sdo_d  = shreg_d[CMD_W-1] & ~cs_n_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shreg_q   <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            new_com_q <= 1'b0;
            com_end_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            cs_n_q    <= cs_n_d;
            new_com_q <= new_com_d;
            com_end_q <= com_end_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rom_addr = idx_q;
    assign bus.sclk     = sclk_q;
    assign bus.sdo      = sdo_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.NewCom   = new_com_q;
    assign bus.ComEnd   = com_end_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_com_sender.sv
// Scoreboard bench for com_sender: stimulus queues expected frames and
// completion events, negedge monitors reassemble SPI frames and compare.
module tb_com_sender;

    localparam int unsigned CMD_W     = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned NUM_CMD   = 3;
    localparam int unsigned CLK_DIV   = 2;
    localparam int          FRAME_CYC = CMD_W * 2 * CLK_DIV;
    localparam int          EV_NEW    = 1;
    localparam int          EV_END    = 2;

    typedef struct {
        logic [15:0] word;
        int          cs_cyc;
    } frame_t;

    typedef struct {
        int kind;
        int at_cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    com_sender_if #(.CMD_W(CMD_W), .ADDR_W(ADDR_W)) bus ();

    com_sender #(
        .CMD_W  (CMD_W),
        .ADDR_W (ADDR_W),
        .NUM_CMD(NUM_CMD),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous command ROM, zero beyond the programmed list.
    logic [15:0] rom [16];
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'hA5C3;
        rom[1] = 16'h0001;
        rom[2] = 16'hFFFF;
    end
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    frame_t frq[$];
    ev_t    evq[$];

    bit          mon_en     = 1'b0;
    bit          aborting   = 1'b0;
    bit          in_frame   = 1'b0;
    logic        prev_cs_n  = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        held_sdo   = 1'b0;
    logic [15:0] got        = '0;
    frame_t      cur;
    int          run_len, phase_err, sdo_err, shift_cyc;
    int          bits        = 0;
    int          frames_done = 0;

    // Frame monitor: rebuilds the word from sdo at each sclk rise and audits timing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_cs_n === 1'b1 && bus.cs_n === 1'b0) begin
                in_frame  = 1'b1;
                run_len   = 1;
                prev_sclk = bus.sclk;
                phase_err = (bus.sclk !== 1'b0) ? 1 : 0;
                sdo_err   = 0;
                shift_cyc = 1;
                bits      = 0;
                got       = '0;
                if (frq.size() == 0) begin
                    chk("unexpected_frame", 32'(frq.size()), 32'd1);
                    cur.word   = 'x;
                    cur.cs_cyc = -1;
                end else begin
                    cur = frq.pop_front();
                    chk("cs_fall_cycle", 32'(cyc), 32'(cur.cs_cyc));
                end
            end else if (in_frame && bus.cs_n === 1'b0) begin
                shift_cyc++;
                if (bus.sclk !== prev_sclk) begin
                    if (run_len != CLK_DIV) phase_err++;
                    run_len = 1;
                    if (bus.sclk === 1'b1) begin
                        got      = {got[14:0], bus.sdo};
                        held_sdo = bus.sdo;
                        bits++;
                    end
                end else begin
                    run_len++;
                    if (bus.sclk === 1'b1 && bus.sdo !== held_sdo) sdo_err++;
                end
                prev_sclk = bus.sclk;
            end else if (in_frame && bus.cs_n === 1'b1) begin
                in_frame = 1'b0;
                if (aborting) begin
                    aborting = 1'b0;
                end else begin
                    if (!(prev_sclk === 1'b1 && run_len == CLK_DIV)) phase_err++;
                    if (bus.sclk !== 1'b0) phase_err++;
                    chk("frame_word",      32'(got),       32'(cur.word));
                    chk("shift_cycles",    32'(shift_cyc), 32'(FRAME_CYC));
                    chk("bit_count",       32'(bits),      32'(CMD_W));
                    chk("sclk_phase_errs", 32'(phase_err), 32'd0);
                    chk("sdo_unstable",    32'(sdo_err),   32'd0);
                    frames_done++;
                end
            end
            prev_cs_n = bus.cs_n;
        end
    end

    logic prev_com_end = 1'b0;
    int   events_seen  = 0;
    int   overlap_err  = 0;

    task automatic take_event(input int kind);
        ev_t e;
        if (evq.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'd0);
        end else begin
            e = evq.pop_front();
            chk("event_kind",  32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc),  32'(e.at_cyc));
        end
        events_seen++;
    endtask

    // Event monitor: each NewCom cycle and each ComEnd rise is one completion.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.NewCom === 1'b1 && bus.ComEnd === 1'b1) overlap_err++;
            if (bus.NewCom === 1'b1) take_event(EV_NEW);
            if (bus.ComEnd === 1'b1 && prev_com_end !== 1'b1) take_event(EV_END);
            prev_com_end = bus.ComEnd;
        end
    end

    task automatic issue_write(input int hold, input bit expect_frame,
                               input logic [15:0] word, input int kind);
        int     k;
        frame_t f;
        ev_t    e;
        @(negedge clk);
        bus.Write = 1'b1;
        @(negedge clk);
        k = cyc;
        if (expect_frame) begin
            f.word   = word;
            f.cs_cyc = k + 2;
            frq.push_back(f);
            e.kind   = kind;
            e.at_cyc = k + 3 + FRAME_CYC;
            evq.push_back(e);
        end
        repeat (hold - 1) @(negedge clk);
        bus.Write = 1'b0;
    endtask

    task automatic wait_event(input int target, input string name);
        int t = 0;
        while (events_seen < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({"event_wait_", name}, 32'(events_seen >= target), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        chk("rst_cs_n",     32'(bus.cs_n),     32'd1);
        chk("rst_sclk",     32'(bus.sclk),     32'd0);
        chk("rst_sdo",      32'(bus.sdo),      32'd0);
        chk("rst_newcom",   32'(bus.NewCom),   32'd0);
        chk("rst_comend",   32'(bus.ComEnd),   32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int activity;
        int t;
        bus.Write = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset  = 1'b0;
        mon_en = 1'b1;

        // First command with NewCom latency, then a long Write held during a frame.
        issue_write(1, 1'b1, 16'hA5C3, EV_NEW);
        wait_event(1, "v1");
        chk("v1_rom_addr", 32'(bus.rom_addr), 32'd1);

        issue_write(10, 1'b1, 16'h0001, EV_NEW);
        chk("v3_busy_during_hold", 32'(bus.busy), 32'd1);
        wait_event(2, "v3");
        chk("v3_rom_addr", 32'(bus.rom_addr), 32'd2);

        issue_write(1, 1'b1, 16'hFFFF, EV_END);
        wait_event(3, "v2_last");
        chk("v2_rom_addr_hold", 32'(bus.rom_addr), 32'd2);
        repeat (5) @(negedge clk);
        chk("v2_comend_sticky", 32'(bus.ComEnd), 32'd1);

        // Requests after the end of the list must be ignored.
        activity = 0;
        issue_write(1, 1'b0, 16'h0000, 0);
        repeat (20) begin
            @(negedge clk);
            if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0 || bus.sclk !== 1'b0) activity++;
        end
        chk("v4_activity", 32'(activity), 32'd0);
        chk("v4_rom_addr", 32'(bus.rom_addr), 32'd2);

        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Abort the second frame mid-shift, then restart the list from the top.
        issue_write(1, 1'b1, 16'hA5C3, EV_NEW);
        wait_event(4, "v5_first");
        issue_write(1, 1'b1, 16'h0001, EV_NEW);
        t = 0;
        while (!(in_frame && bits >= 7) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("v5_reached_bit7", 32'(in_frame && bits >= 7), 32'd1);
        aborting = 1'b1;
        evq.delete();
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("v5_no_completion", 32'(events_seen), 32'd4);

        issue_write(1, 1'b1, 16'hA5C3, EV_NEW);
        wait_event(5, "v5_resend");
        chk("v5_rom_addr", 32'(bus.rom_addr), 32'd1);
        issue_write(1, 1'b1, 16'h0001, EV_NEW);
        wait_event(6, "v5_second");
        issue_write(1, 1'b1, 16'hFFFF, EV_END);
        wait_event(7, "v5_third");
        chk("v5_comend", 32'(bus.ComEnd), 32'd1);

        repeat (5) @(negedge clk);
        chk("newcom_comend_overlap", 32'(overlap_err), 32'd0);
        chk("frames_completed",      32'(frames_done), 32'd7);
        chk("frame_queue_left",      32'(frq.size()),  32'd0);
        chk("event_queue_left",      32'(evq.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
